// File: rtl/mod_2n1_mul_seq.sv
// mod_2n1_mul_seq: sequential (a*b) mod (2^N+1) multiplier, MSB-first Horner, valid/ready handshakes
module mod_2n1_mul_seq #(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [N:0] in_a,
    input  logic [N:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [N:0] out_p
);
    localparam int CW = $clog2(N + 1);
    localparam logic [N+2:0] MOD = {3'b001, {N{1'b0}}} + {{(N+2){1'b0}}, 1'b1};
    localparam logic [N+2:0] MOD2 = {MOD[N+1:0], 1'b0};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_n;
    logic [N:0]    a_r, b_r, acc, acc_n, a_in, b_in;
    logic [CW-1:0] cnt;
    logic [N+2:0]  t, tr;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // operand pre-reduction (one subtraction suffices) and one Horner step with k in {0,1,2}
    always_comb begin
        a_in  = in_a >= MOD[N:0] ? in_a - MOD[N:0] : in_a;
        b_in  = in_b >= MOD[N:0] ? in_b - MOD[N:0] : in_b;
        t     = {1'b0, acc, 1'b0} + (b_r[cnt] ? {2'b00, a_r} : '0);
        tr    = t >= MOD2 ? t - MOD2 : t >= MOD ? t - MOD : t;
        acc_n = tr[N:0];
    end

    // next-state decode
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? BUSY : IDLE;
            BUSY:    state_n = cnt == '0 ? DONE : BUSY;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // datapath: capture reduced operands, step the accumulator, latch the result
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            out_p <= '0;
        end else if (state == IDLE && in_valid) begin
            a_r <= a_in;
            b_r <= b_in;
            acc <= '0;
            cnt <= CW'(N);
        end else if (state == BUSY) begin
            acc <= acc_n;
            cnt <= cnt - CW'(1);
            if (cnt == '0) out_p <= acc_n;
        end
    end
endmodule

// File: tb/tb_mod_2n1_mul_seq.sv
// tb_mod_2n1_mul_seq: directed and random checks of the modulo-(2^N+1) multiplier at N=4 and N=8
module tb_mod_2n1_mul_seq;
    logic       clk = 0;
    logic       rst;
    logic       v4, rdy4, ov4, ro4;
    logic [4:0] a4, b4, p4;
    logic       v8, rdy8, ov8, ro8;
    logic [8:0] a8, b8, p8;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod_2n1_mul_seq #(.N(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_a(a4), .in_b(b4),
        .out_valid(ov4), .out_ready(ro4), .out_p(p4)
    );

    mod_2n1_mul_seq #(.N(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
        .out_valid(ov8), .out_ready(ro8), .out_p(p8)
    );

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] p;
    } vec4_t;

    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        logic [8:0] p;
    } vec8_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic op4(input logic [4:0] a, input logic [4:0] b, output logic [4:0] p, output int lat);
        @(negedge clk);
        v4 = 1; a4 = a; b4 = b;
        for (int i = 0; i < 50 && !rdy4; i++) @(negedge clk);
        @(negedge clk);
        v4 = 0;
        lat = 0;
        while (!ov4 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        p = p4;
        ro4 = 1;
        @(negedge clk);
        ro4 = 0;
    endtask

    task automatic op8(input logic [8:0] a, input logic [8:0] b, output logic [8:0] p, output int lat);
        @(negedge clk);
        v8 = 1; a8 = a; b8 = b;
        for (int i = 0; i < 50 && !rdy8; i++) @(negedge clk);
        @(negedge clk);
        v8 = 0;
        lat = 0;
        while (!ov8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        p = p8;
        ro8 = 1;
        @(negedge clk);
        ro8 = 0;
    endtask

    initial begin
        vec4_t t4[10];
        vec8_t t8[4];
        logic [4:0] r4;
        logic [8:0] r8;
        int lat, extra, got, cyc;
        int qa[$], qb[$];

        t4[0] = '{5'd16, 5'd16, 5'd1};
        t4[1] = '{5'd16, 5'd2,  5'd15};
        t4[2] = '{5'd0,  5'd13, 5'd0};
        t4[3] = '{5'd5,  5'd7,  5'd1};
        t4[4] = '{5'd31, 5'd3,  5'd8};
        t4[5] = '{5'd17, 5'd9,  5'd0};
        t4[6] = '{5'd31, 5'd31, 5'd9};
        t4[7] = '{5'd1,  5'd16, 5'd16};
        t4[8] = '{5'd20, 5'd20, 5'd9};
        t4[9] = '{5'd3,  5'd4,  5'd12};
        t8[0] = '{9'd256, 9'd256, 9'd1};
        t8[1] = '{9'd200, 9'd150, 9'd188};
        t8[2] = '{9'd511, 9'd2,   9'd251};
        t8[3] = '{9'd0,   9'd511, 9'd0};

        rst = 1; v4 = 0; a4 = 0; b4 = 0; ro4 = 0; v8 = 0; a8 = 0; b8 = 0; ro8 = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("reset_in_ready4", rdy4, 1);
        chk("reset_out_valid4", ov4, 0);
        chk("reset_out_p4", p4, 0);
        chk("reset_in_ready8", rdy8, 1);
        chk("reset_out_valid8", ov8, 0);
        chk("reset_out_p8", p8, 0);

        for (int i = 0; i < 10; i++) begin
            op4(t4[i].a, t4[i].b, r4, lat);
            chk($sformatf("n4_p[%0d:%0d*%0d]", i, t4[i].a, t4[i].b), r4, t4[i].p);
            chk($sformatf("n4_lat[%0d]", i), lat, 5);
        end
        for (int i = 0; i < 4; i++) begin
            op8(t8[i].a, t8[i].b, r8, lat);
            chk($sformatf("n8_p[%0d:%0d*%0d]", i, t8[i].a, t8[i].b), r8, t8[i].p);
            chk($sformatf("n8_lat[%0d]", i), lat, 9);
        end

        // backpressure: 3*4 = 12 held while out_ready is low
        @(negedge clk);
        v4 = 1; a4 = 3; b4 = 4;
        @(negedge clk);
        v4 = 0;
        for (int i = 0; i < 50 && !ov4; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("stall_out_valid", ov4, 1);
            chk("stall_out_p", p4, 12);
            chk("stall_in_ready", rdy4, 0);
            @(negedge clk);
        end
        ro4 = 1;
        @(negedge clk);
        ro4 = 0;
        chk("release_out_valid", ov4, 0);
        chk("release_in_ready", rdy4, 1);
        chk("release_out_p_kept", p4, 12);

        // reset during BUSY: accept 9*9 at edge T, rst sampled at T+2
        @(negedge clk);
        v4 = 1; a4 = 9; b4 = 9;
        @(negedge clk);
        v4 = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (ov4 || p4 != 0) extra++;
            @(negedge clk);
        end
        chk("rst_busy_no_result", extra, 0);
        chk("rst_busy_out_p", p4, 0);
        chk("rst_busy_in_ready", rdy4, 1);
        op4(5'd2, 5'd3, r4, lat);
        chk("after_rst_p", r4, 6);
        chk("after_rst_lat", lat, 5);

        // ignored inputs during BUSY/DONE
        @(negedge clk);
        v4 = 1; a4 = 5; b4 = 7;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rdy4) extra++;
            v4 = 1'($urandom);
            a4 = 5'($urandom);
            b4 = 5'($urandom);
        end
        v4 = 0;
        chk("ignored_no_accept", extra, 0);
        chk("ignored_out_valid", ov4, 1);
        chk("ignored_out_p", p4, 1);
        ro4 = 1;
        @(negedge clk);
        ro4 = 0;
        chk("ignored_in_ready", rdy4, 1);
        chk("ignored_out_valid_low", ov4, 0);

        // back-to-back random stream, N=8, both sides always willing
        got = 0; cyc = 0;
        ro8 = 1; v8 = 1;
        @(negedge clk);
        while (got < 1000 && cyc < 20000) begin
            if (ov8) begin
                chk($sformatf("stream[%0d:%0d*%0d]", got, qa[0], qb[0]), p8, (qa[0] * qb[0]) % 257);
                void'(qa.pop_front());
                void'(qb.pop_front());
                got++;
            end
            if (rdy8) begin
                a8 = 9'($urandom);
                b8 = 9'($urandom);
                qa.push_back(int'(a8));
                qb.push_back(int'(b8));
            end
            @(negedge clk);
            cyc++;
        end
        v8 = 0; ro8 = 0;
        chk("stream_count", got, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
